servo_track_history: RTL and testbench

//  Parametrised successor of the servo xy history register: circular buffer of the last DEPTH

---
 rtl/servo_track_history.sv | 119 +++++++++++
 tb/tb_servo_track_history.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/servo_track_history.sv
// Circular history of the last DEPTH multi-channel servo samples, replayed newest-first on request.
// Outputs per-channel park values whenever no replay is in progress.
module servo_track_history #(
    parameter int unsigned     CH        = 2,
    parameter int unsigned     W         = 11,
    parameter int unsigned     DEPTH     = 25,
    parameter logic [CH*W-1:0] PARK_VALS = {11'd1500, 11'd1200}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic                         clear,
    input  logic                         bt_start,
    input  logic                         bt_abort,
    input  logic [CH*W-1:0]              sample_in,
    output logic [CH*W-1:0]              sample_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         bt_done,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic {REC, REPLAY} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CH*W-1:0]   sample_out_q, sample_out_d;
    logic              out_valid_q, out_valid_d;
    logic              bt_done_q, bt_done_d;
    logic [PW-1:0]     rd_ptr;
    logic              mem_we;
    logic [CH*W-1:0]   mem_q [DEPTH];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        bt_done_d    = 1'b0;
        mem_we       = 1'b0;
        rd_ptr       = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PW'(1);

        if (clear) begin
            state_d      = REC;
            wr_ptr_d     = '0;
            count_d      = '0;
            sample_out_d = PARK_VALS;
        end else if (state_q == REPLAY) begin
            if (bt_abort) begin
                state_d      = REC;
                sample_out_d = PARK_VALS;
            end else if (ce) begin
                // Popping rewinds wr_ptr so a later recording resumes right after the newest survivor.
                wr_ptr_d     = rd_ptr;
                sample_out_d = mem_q[rd_ptr];
                out_valid_d  = 1'b1;
                count_d      = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    bt_done_d = 1'b1;
                    state_d   = REC;
                end
            end
        end else begin
            if (ce) begin
                mem_we       = 1'b1;
                wr_ptr_d     = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
                sample_out_d = PARK_VALS;
                if (count_q != CNT_FULL) begin
                    count_d = count_q + CW'(1);
                end
            end
            // A same-cycle ce guarantees at least one entry to replay.
            if (bt_start) begin
                if (ce || count_q != '0) begin
                    state_d = REPLAY;
                end else begin
                    bt_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REC;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            sample_out_q <= PARK_VALS;
            out_valid_q  <= 1'b0;
            bt_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            bt_done_q    <= bt_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign bt_done    = bt_done_q;
    assign busy       = (state_q == REPLAY);
    assign count      = count_q;

endmodule

// File: tb/tb_servo_track_history.sv
// Bench for servo_track_history: vector table, directed corner sequences and a random run
// compared against a queue-based history model.
module tb_servo_track_history;
    localparam int CH    = 2;
    localparam int W     = 11;
    localparam int DEPTH = 25;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CH*W-1:0] PARK = {11'd1500, 11'd1200};

    logic            clk = 1'b0;
    logic            rst, ce, clear, bt_start, bt_abort;
    logic [CH*W-1:0] sample_in, sample_out;
    logic            out_valid, busy, bt_done;
    logic [CW-1:0]   count;

    always #5 clk = ~clk;

    servo_track_history #(
        .CH(CH), .W(W), .DEPTH(DEPTH), .PARK_VALS(PARK)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .clear(clear), .bt_start(bt_start), .bt_abort(bt_abort),
        .sample_in(sample_in), .sample_out(sample_out), .out_valid(out_valid), .busy(busy),
        .bt_done(bt_done), .count(count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: history is a queue, oldest at front, newest at back.
    logic [CH*W-1:0] m_hist[$];
    bit              m_rep;
    logic [CH*W-1:0] m_out;
    bit              m_ov, m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_rep  = 0;
        m_out  = PARK;
        m_ov   = 0;
        m_done = 0;
    endtask

    task automatic model_step(input bit c, input bit clr, input bit st, input bit ab,
                              input logic [CH*W-1:0] s);
        m_ov   = 0;
        m_done = 0;
        if (clr) begin
            m_hist.delete();
            m_rep = 0;
            m_out = PARK;
        end else if (m_rep && ab) begin
            m_rep = 0;
            m_out = PARK;
        end else if (!m_rep) begin
            if (c) begin
                m_hist.push_back(s);
                if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
                m_out = PARK;
            end
            if (st) begin
                if (m_hist.size() > 0) m_rep = 1;
                else m_done = 1;
            end
        end else if (c) begin
            m_out = m_hist.pop_back();
            m_ov  = 1;
            if (m_hist.size() == 0) begin
                m_done = 1;
                m_rep  = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sample_out"}, 32'(sample_out), 32'(m_out));
        chk({tag, ".out_valid"},  32'(out_valid),  32'(m_ov));
        chk({tag, ".busy"},       32'(busy),       32'(m_rep));
        chk({tag, ".bt_done"},    32'(bt_done),    32'(m_done));
        chk({tag, ".count"},      32'(count),      32'(m_hist.size()));
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 ns after the edge.
    task automatic step(input bit c, input bit clr, input bit st, input bit ab,
                        input int x, input int y, input bit do_chk, input string tag);
        ce        = c;
        clear     = clr;
        bt_start  = st;
        bt_abort  = ab;
        sample_in = {11'(x), 11'(y)};
        @(posedge clk);
        model_step(c, clr, st, ab, {11'(x), 11'(y)});
        #1;
        if (do_chk) check_model(tag);
        ce = 0; clear = 0; bt_start = 0; bt_abort = 0;
    endtask

    typedef struct {
        bit c, clr, st, ab;
        int x, y;
        int ex, ey;
        bit ev, eb, ed;
        int ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit c, bit clr, bit st, bit ab, int x, int y,
                                int ex, int ey, bit ev, bit eb, bit ed, int ecnt);
        vec_t v;
        v.c = c; v.clr = clr; v.st = st; v.ab = ab; v.x = x; v.y = y;
        v.ex = ex; v.ey = ey; v.ev = ev; v.eb = eb; v.ed = ed; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        //            ce clr st ab  x    y     ex    ey   ov busy done cnt
        vecs.push_back(mk(1, 0, 0, 0, 100, 200, 1500, 1200, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 101, 201, 1500, 1200, 0, 0, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 102, 202, 1500, 1200, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 1, 0,   0,   0, 1500, 1200, 0, 1, 0, 3));
        vecs.push_back(mk(1, 0, 0, 0, 999, 999,  102,  202, 1, 1, 0, 2));
        vecs.push_back(mk(1, 0, 1, 0, 999, 999,  101,  201, 1, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 999, 999,  100,  200, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0,  100,  200, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  55,  66, 1500, 1200, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,   0,   0, 1500, 1200, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,   0,   0, 1500, 1200, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0,   0, 1500, 1200, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0,   7,   8, 1500, 1200, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0,   9,   9,    7,    8, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1,   3,   4, 1500, 1200, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,   0,   0, 1500, 1200, 0, 0, 0, 0));

        rst = 1; ce = 0; clear = 0; bt_start = 0; bt_abort = 0; sample_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst = 0;

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].clr, vecs[i].st, vecs[i].ab, vecs[i].x, vecs[i].y, 0, "");
            chk($sformatf("vec%0d.sample_out", i), 32'(sample_out), 32'({11'(vecs[i].ex), 11'(vecs[i].ey)}));
            chk($sformatf("vec%0d.out_valid", i),  32'(out_valid),  32'(vecs[i].ev));
            chk($sformatf("vec%0d.busy", i),       32'(busy),       32'(vecs[i].eb));
            chk($sformatf("vec%0d.bt_done", i),    32'(bt_done),    32'(vecs[i].ed));
            chk($sformatf("vec%0d.count", i),      32'(count),      32'(vecs[i].ecnt));
        end
        model_reset();

        // Overfill: only the newest DEPTH samples survive.
        for (int i = 0; i < 30; i++) step(1, 0, 0, 0, i, 500 + i, 1, "fill");
        chk("fill.count", 32'(count), 32'(DEPTH));
        step(0, 0, 1, 0, 0, 0, 1, "fill.start");
        for (int k = 0; k < DEPTH; k++) begin
            step(1, 0, 0, 0, 0, 0, 1, "fill.pop");
            chk($sformatf("fill.pop%0d", k), 32'(sample_out), 32'({11'(29 - k), 11'(529 - k)}));
            chk($sformatf("fill.done%0d", k), 32'(bt_done), 32'(k == DEPTH - 1));
        end
        chk("fill.count_end", 32'(count), 0);

        // Abort keeps the unreplayed remainder.
        step(0, 1, 0, 0, 0, 0, 1, "ab.clear");
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, i, i, 1, "ab.rec");
        step(0, 0, 1, 0, 0, 0, 1, "ab.start");
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0, 0, 0, 1, "ab.pop");
            chk($sformatf("ab.pop%0d", k), 32'(sample_out), 32'({11'(9 - k), 11'(9 - k)}));
        end
        step(1, 0, 0, 1, 0, 0, 1, "ab.abort");
        chk("ab.park", 32'(sample_out), 32'(PARK));
        chk("ab.count", 32'(count), 6);
        step(0, 0, 1, 0, 0, 0, 1, "ab.restart");
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 0, 0, 0, 0, 1, "ab.pop2");
            chk($sformatf("ab.pop2_%0d", k), 32'(sample_out), 32'({11'(5 - k), 11'(5 - k)}));
            chk($sformatf("ab.done%0d", k), 32'(bt_done), 32'(k == 5));
        end

        // Clear mid-replay.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 40 + i, 60 + i, 1, "clr.rec");
        step(0, 0, 1, 0, 0, 0, 1, "clr.start");
        step(1, 0, 0, 0, 0, 0, 1, "clr.pop");
        step(0, 1, 0, 0, 0, 0, 1, "clr.clear");
        chk("clr.count", 32'(count), 0);
        chk("clr.busy", 32'(busy), 0);

        // Asynchronous reset between edges, right after a pop raised out_valid.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 70 + i, 80 + i, 1, "rst.rec");
        step(0, 0, 1, 0, 0, 0, 1, "rst.start");
        step(1, 0, 0, 0, 0, 0, 1, "rst.pop");
        chk("rst.pre_valid", 32'(out_valid), 1);
        #3;
        rst = 1;
        #1;
        model_reset();
        check_model("rst.async");
        @(negedge clk);
        rst = 0;

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(1, 0) == 1, $urandom_range(63, 0) == 0,
                 $urandom_range(7, 0) == 0, $urandom_range(15, 0) == 0,
                 int'($urandom_range(2047, 0)), int'($urandom_range(2047, 0)), 1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
